spi_slave_fl: RTL and testbench
===============================

# spi_slave_fl

SPI flash-style responder: the slave end of the command/address/data serial protocol used by the team's flash SPI master. It oversamples `sclk`/`ss`/`mosi` in the `clk` domain, deserialises an 8-bit command, optional 24-bit address and optional 32-bit write data, and returns up to 32 answer bits on `miso`. It sits between the SPI pins and a local register/memory model that decodes commands and supplies answer data.

## Interface
- `CMD_W`, 8, command field width
- `ADDR_W`, 24, address field width
- `DATA_W`, 32, write-data and answer field width
- `clk`  in  1  system clock; must be ≥ 8× the sclk frequency
- `rst`  in  1  reset, asynchronous, active-high
- `sclk`  in  1  SPI clock from master (asynchronous to clk)
- `ss`  in  1  slave select, active-low
- `mosi`  in  1  master-out data, MSB first
- `miso`  out  1  slave-out data, MSB first
- `cmd`  out  CMD_W  captured command, held until next frame's command completes
- `cmd_valid`  out  1  one-clk pulse when all command bits are captured
- `cmd_type`  in  3  frame layout for `cmd`, sampled in the `cmd_valid` cycle
- `tx_data`  in  DATA_W  answer word, sampled in the cycle the answer phase starts
- `tx_nbits`  in  6  answer length 1..32, sampled with `cmd_type`; 0 treated as 32
- `rx_address`  out  ADDR_W  captured address
- `rx_data`  out  DATA_W  captured write data
- `rx_valid`  out  1  one-clk pulse: frame complete and well-formed
- `tx_done`  out  1  one-clk pulse: last answer bit driven
- `frame_err`  out  1  one-clk pulse: ss deasserted before expected bits completed

## Operation
- Input sync: two-flop synchronisers on `sclk`, `ss`, `mosi`; rising/falling sclk edges detected from synchronised sclk.
- `cmd_type` encoding: 000 cmd; 001 cmd+answer; 010 cmd+addr+answer; 011 cmd+data; 100 cmd+addr+data; 101 cmd+addr; 110/111 treated as 000.
- FSM states: IDLE, CMD, ADDR, DATA, ANSWER, DONE.
- IDLE → CMD on synchronised ss falling; bit counter loaded with CMD_W-1.
- CMD/ADDR/DATA: shift `mosi` in on each sclk rising edge; at counter 0 advance per `cmd_type` (ADDR, DATA, ANSWER or DONE). Counter reloads with the field width minus 1.
- ANSWER: on entry load shift register with `tx_data`, counter with nbits-1; drive `tx_data[DATA_W-1]` at the first sclk falling edge after the rising edge that captured the last receive bit; shift one bit per subsequent falling edge; pulse `tx_done` after the falling edge that drives the last bit; → DONE.
- DONE: further sclk edges ignored, `miso` = 0; on ss rising pulse `rx_valid`, → IDLE.
- ss rising in any state other than IDLE/DONE: pulse `frame_err`, no `rx_valid`, → IDLE; partial fields are not written to `rx_address`/`rx_data`.
- `rx_address`/`rx_data` update only when the respective field completes; unused fields keep their previous values.

## Timing
- Reset values: `miso`=0, `cmd`=0, `cmd_valid`=0, `rx_address`=0, `rx_data`=0, `rx_valid`=0, `tx_done`=0, `frame_err`=0, state IDLE.
- Pin-to-capture latency: 3 clk cycles after the sclk rising edge (2 sync + 1 edge detect).
- `miso` changes within 3 clk cycles of the sclk falling edge; setup to the master's next rising edge is guaranteed by the 8× ratio.
- `cmd_valid` is asserted 3 clk cycles after the 8th sclk rising edge; `cmd_type`/`tx_nbits` must be valid that same cycle (combinational decode by the consumer is permitted).
- `rx_valid`/`frame_err` asserted 3 clk cycles after the pin-level ss rising edge; never both.
- rst mid-frame: immediate return to IDLE, all outputs to reset values; frame not resumed until a new ss falling edge.
- ss falling while in DONE is impossible (requires ss rising first); ss held low after DONE holds state.

## Configuration
- `SPI_SLAVE_MISO_TRISTATE_EN` defined: `miso` is high-impedance whenever ss (synchronised) is high or state is IDLE/DONE; driven only in ANSWER.
- Not defined: `miso` driven 0 outside ANSWER.

## Test plan
- cmd_type 000, cmd 0x06 -> `cmd`=0x06, one `cmd_valid`, one `rx_valid`, no `tx_done`, miso stays 0.
- cmd 0x9F, type 001, tx_data 0xC2201600, nbits 24 -> miso shifts 0xC22016 MSB first starting at the falling edge after bit 8; one `tx_done`; `rx_valid` at ss rise.
- cmd 0x03, type 010, address 0x123456, tx_data 0xDEADBEEF, nbits 32 -> `rx_address`=0x123456, master receives 0xDEADBEEF.
- cmd 0x02, type 100, address 0x000100, data 0xA5A5_0F0F -> `rx_address`=0x000100, `rx_data`=0xA5A50F0F, `rx_valid` pulse.
- type 100 frame with ss raised after 20 bits -> `frame_err` pulse, no `rx_valid`, `rx_address`/`rx_data` unchanged, next frame decodes normally.
- rst asserted during ANSWER bit 10 -> miso=0 (or Z with macro) immediately, no `tx_done`; subsequent 0x9F frame returns correct data.

Source files
------------

// File: rtl/spi_slave_fl_if.sv
// Pin and consumer bundle for spi_slave_fl.
// The slave modport is the responder's view; the master modport is the driving side.
interface spi_slave_fl_if #(
  parameter int CMD_W  = 8,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              sclk;
  logic              ss;
  logic              mosi;
  wire               miso;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_valid;
  logic [2:0]        cmd_type;
  logic [DATA_W-1:0] tx_data;
  logic [5:0]        tx_nbits;
  logic [ADDR_W-1:0] rx_address;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_done;
  logic              frame_err;

  modport slave (
    input  sclk, ss, mosi, cmd_type, tx_data, tx_nbits,
    output miso, cmd, cmd_valid, rx_address, rx_data, rx_valid, tx_done, frame_err
  );
  modport master (
    output sclk, ss, mosi, cmd_type, tx_data, tx_nbits,
    input  miso, cmd, cmd_valid, rx_address, rx_data, rx_valid, tx_done, frame_err
  );
endinterface

// File: rtl/spi_slave_fl.sv
// Oversampled SPI flash-style responder: cmd / optional addr / optional data in, up to 32 answer bits out.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float miso whenever the answer phase is not active.
module spi_slave_fl #(
  parameter int CMD_W  = 8,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  spi_slave_fl_if.slave bus
);
  localparam int CW = 6;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ANSWER, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        sclk_p, ss_p;
  logic [1:0]        mosi_p;
  logic              rise, fall, ss_fall, ss_rise, mosi_s;
  logic [2:0]        type_in, type_q;
  logic [CW-1:0]     cnt, nbits_q;
  logic [DATA_W-2:0] sh;
  logic [DATA_W-1:0] tx_sh;
  logic              ans_load, last_q, miso_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              cmd_valid_q, rx_valid_q, tx_done_q, frame_err_q;
  logic              bit_done, cap, rx_ok, err;

  // ss sync resets low so a frame already in progress at reset release is not picked up mid-way
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_p <= '0;
      ss_p   <= '0;
      mosi_p <= '0;
    end else begin
      sclk_p <= {sclk_p[1:0], bus.sclk};
      ss_p   <= {ss_p[1:0], bus.ss};
      mosi_p <= {mosi_p[0], bus.mosi};
    end

  assign rise     = sclk_p[1] & ~sclk_p[2];
  assign fall     = ~sclk_p[1] & sclk_p[2];
  assign ss_fall  = ~ss_p[1] & ss_p[2];
  assign ss_rise  = ss_p[1] & ~ss_p[2];
  assign mosi_s   = mosi_p[1];
  assign type_in  = (bus.cmd_type > 3'b101) ? 3'b000 : bus.cmd_type;
  assign bit_done = rise && (cnt == '0);
  assign cap      = bit_done && !ss_rise;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    rx_ok     = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE:   if (ss_fall) state_nxt = CMD;
      // layout is decoded in the cmd_valid cycle so the consumer may decode cmd combinationally
      CMD:    if (cmd_valid_q)
                unique case (type_in)
                  3'b000:  state_nxt = DONE;
                  3'b001:  state_nxt = ANSWER;
                  3'b011:  state_nxt = DATA;
                  default: state_nxt = ADDR;
                endcase
      ADDR:   if (bit_done)
                state_nxt = (type_q == 3'b010) ? ANSWER : (type_q == 3'b100) ? DATA : DONE;
      DATA:   if (bit_done) state_nxt = DONE;
      // last bit stays on miso until the master's sampling edge
      ANSWER: if (last_q && rise) state_nxt = DONE;
      DONE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (ss_rise && state != IDLE) begin
      state_nxt = IDLE;
      if (state == DONE || (state == ANSWER && last_q)) rx_ok = 1'b1;
      else                                              err   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      nbits_q     <= '0;
      type_q      <= '0;
      sh          <= '0;
      tx_sh       <= '0;
      ans_load    <= 1'b0;
      last_q      <= 1'b0;
      miso_q      <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_valid_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_valid_q  <= rx_ok;
      frame_err_q <= err;
      if (rise && (state == CMD || state == ADDR || state == DATA)) begin
        sh  <= {sh[DATA_W-3:0], mosi_s};
        cnt <= cnt - 1'b1;
      end
      if (state_nxt == ANSWER && state != ANSWER) ans_load <= 1'b1;
      case (state)
        IDLE: begin
          cnt      <= CW'(CMD_W - 1);
          last_q   <= 1'b0;
          ans_load <= 1'b0;
        end
        CMD: begin
          if (cap) begin
            cmd_q       <= {sh[CMD_W-2:0], mosi_s};
            cmd_valid_q <= 1'b1;
          end
          if (cmd_valid_q) begin
            type_q  <= type_in;
            nbits_q <= (bus.tx_nbits == '0 || bus.tx_nbits > CW'(DATA_W)) ?
                       CW'(DATA_W - 1) : bus.tx_nbits - 1'b1;
            cnt     <= (type_in == 3'b011) ? CW'(DATA_W - 1) : CW'(ADDR_W - 1);
          end
        end
        ADDR: if (cap) begin
          addr_q <= {sh[ADDR_W-2:0], mosi_s};
          cnt    <= CW'(DATA_W - 1);
        end
        DATA: if (cap) data_q <= {sh, mosi_s};
        ANSWER: begin
          // tx_data is taken one cycle into the phase so it may depend on the fresh rx_address
          if (ans_load) begin
            tx_sh    <= bus.tx_data;
            cnt      <= nbits_q;
            ans_load <= 1'b0;
          end else if (fall && !last_q) begin
            miso_q <= tx_sh[DATA_W-1];
            tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
            if (cnt == '0) begin
              tx_done_q <= 1'b1;
              last_q    <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (state_nxt != ANSWER) miso_q <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.miso = (state == ANSWER && !ss_p[1]) ? miso_q : 1'bz;
`else
  assign bus.miso = miso_q;
`endif
  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.rx_address = addr_q;
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_spi_slave_fl.sv
// Bench for spi_slave_fl: fixed frame table, reset-mid-answer sequence, then random frames vs a frame-level model.
module tb_spi_slave_fl;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_fl_if #(.CMD_W(8), .ADDR_W(24), .DATA_W(32)) bus();
  spi_slave_fl #(.CMD_W(8), .ADDR_W(24), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_RST = 1'bz;
`else
  localparam logic MISO_RST = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int c_cv = 0, c_rv = 0, c_td = 0, c_fe = 0, c_m1 = 0;
  int d_cv, d_rv, d_td, d_fe, d_m1;
  logic [7:0]  m_cmd;
  logic [23:0] m_addr;
  logic [31:0] m_data;

  always @(negedge clk) begin
    c_cv <= c_cv + int'(bus.cmd_valid === 1'b1);
    c_rv <= c_rv + int'(bus.rx_valid === 1'b1);
    c_td <= c_td + int'(bus.tx_done === 1'b1);
    c_fe <= c_fe + int'(bus.frame_err === 1'b1);
    c_m1 <= c_m1 + int'(bus.miso === 1'b1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int norm(input logic [2:0] t);
    return (t > 3'd5) ? 0 : int'(t);
  endfunction
  function automatic bit has_a(input int tn);
    return tn == 2 || tn == 4 || tn == 5;
  endfunction
  function automatic bit has_d(input int tn);
    return tn == 3 || tn == 4;
  endfunction
  function automatic int rx_len(input int tn);
    return 8 + (has_a(tn) ? 24 : 0) + (has_d(tn) ? 32 : 0);
  endfunction
  function automatic int ans_len(input int tn, input logic [5:0] nb);
    if (tn != 1 && tn != 2) return 0;
    return (nb == 6'd0) ? 32 : int'(nb);
  endfunction

  // Mode-0 master: mosi set while sclk low, miso sampled just before each rising edge.
  // nclk < 0 runs the whole frame; otherwise ss rises after nclk sclk cycles.
  task automatic xfer(input logic [7:0] c, input logic [2:0] t, input logic [23:0] a,
                      input logic [31:0] d, input logic [31:0] txd, input logic [5:0] nb,
                      input int nclk, input bit do_rst, output logic [31:0] ans);
    logic q[$];
    int tn, nrx, total, b_cv, b_rv, b_td, b_fe, b_m1;
    tn = norm(t);
    for (int i = 7; i >= 0; i--) q.push_back(c[i]);
    if (has_a(tn)) for (int i = 23; i >= 0; i--) q.push_back(a[i]);
    if (has_d(tn)) for (int i = 31; i >= 0; i--) q.push_back(d[i]);
    nrx   = q.size();
    total = (nclk < 0) ? nrx + ans_len(tn, nb) : nclk;
    bus.cmd_type = t;
    bus.tx_nbits = nb;
    bus.tx_data  = txd;
    ans  = '0;
    b_cv = c_cv; b_rv = c_rv; b_td = c_td; b_fe = c_fe; b_m1 = c_m1;
    bus.ss = 1'b0;
    clks(HALF);
    for (int i = 0; i < total; i++) begin
      bus.mosi = (i < nrx) ? q[i] : 1'b0;
      clks(HALF);
      if (i >= nrx) ans = {ans[30:0], bus.miso};
      bus.sclk = 1'b1;
      clks(HALF);
      bus.sclk = 1'b0;
    end
    clks(HALF);
    if (do_rst) begin
      check("miso_before_rst", 32'(bus.miso), 32'(1'b1));
      rst = 1'b1;
      #1;
      check("miso_in_rst", {31'd0, bus.miso}, {31'd0, MISO_RST});
      check("cmd_in_rst", 32'(bus.cmd), 32'd0);
      clks(3);
      rst = 1'b0;
      clks(2);
    end
    bus.ss = 1'b1;
    clks(2 * HALF);
    d_cv = c_cv - b_cv; d_rv = c_rv - b_rv; d_td = c_td - b_td;
    d_fe = c_fe - b_fe; d_m1 = c_m1 - b_m1;
  endtask

  task automatic run_model(input logic [7:0] c, input logic [2:0] t, input logic [23:0] a,
                           input logic [31:0] d, input logic [31:0] txd, input logic [5:0] nb,
                           input int nclk);
    int tn, nans;
    bit full;
    logic [31:0] ans;
    tn   = norm(t);
    nans = ans_len(tn, nb);
    full = (nclk < 0);
    xfer(c, t, a, d, txd, nb, nclk, 1'b0, ans);
    if (full || nclk >= 8) m_cmd = c;
    if (has_a(tn) && (full || nclk >= 32)) m_addr = a;
    if (has_d(tn) && full) m_data = d;
    check("m_cmd", 32'(bus.cmd), 32'(m_cmd));
    check("m_addr", 32'(bus.rx_address), 32'(m_addr));
    check("m_data", bus.rx_data, m_data);
    check("m_cmd_valid", 32'(d_cv), 32'(full || nclk >= 8));
    check("m_rx_valid", 32'(d_rv), 32'(full));
    check("m_frame_err", 32'(d_fe), 32'(!full));
    check("m_tx_done", 32'(d_td), 32'(full && nans > 0));
    if (full && nans > 0) check("m_answer", ans, txd >> (32 - nans));
    if (nans == 0) check("m_miso_quiet", 32'(d_m1), 32'd0);
  endtask

  typedef struct packed {
    logic [7:0]  c;
    logic [2:0]  t;
    logic [23:0] a;
    logic [31:0] d;
    logic [31:0] txd;
    logic [5:0]  nb;
    int          nclk;
    logic [31:0] e_ans;
    logic [23:0] e_a;
    logic [31:0] e_d;
    logic        e_err;
  } vec_t;

  vec_t tbl [0:9];

  initial begin
    logic [31:0] ans;
    int tn, nans, nclk;
    logic [2:0] t;
    tbl[0] = '{8'h06, 3'b000, 24'h0,      32'h0,        32'h0,        6'd0,  -1, 32'h0,        24'h0,      32'h0,        1'b0};
    tbl[1] = '{8'h9F, 3'b001, 24'h0,      32'h0,        32'hC2201600, 6'd24, -1, 32'h00C22016, 24'h0,      32'h0,        1'b0};
    tbl[2] = '{8'h03, 3'b010, 24'h123456, 32'h0,        32'hDEADBEEF, 6'd32, -1, 32'hDEADBEEF, 24'h123456, 32'h0,        1'b0};
    tbl[3] = '{8'h02, 3'b100, 24'h000100, 32'hA5A50F0F, 32'h0,        6'd0,  -1, 32'h0,        24'h000100, 32'hA5A50F0F, 1'b0};
    tbl[4] = '{8'h02, 3'b100, 24'hFFFFFF, 32'h11111111, 32'h0,        6'd0,  20, 32'h0,        24'h000100, 32'hA5A50F0F, 1'b1};
    tbl[5] = '{8'h05, 3'b011, 24'h0,      32'h12345678, 32'h0,        6'd0,  -1, 32'h0,        24'h000100, 32'h12345678, 1'b0};
    tbl[6] = '{8'h20, 3'b101, 24'hABCDEF, 32'h0,        32'h0,        6'd0,  -1, 32'h0,        24'hABCDEF, 32'h12345678, 1'b0};
    tbl[7] = '{8'h0B, 3'b001, 24'h0,      32'h0,        32'h0F0F0F0F, 6'd0,  -1, 32'h0F0F0F0F, 24'hABCDEF, 32'h12345678, 1'b0};
    tbl[8] = '{8'h35, 3'b010, 24'h000001, 32'h0,        32'h80000000, 6'd1,  -1, 32'h1,        24'h000001, 32'h12345678, 1'b0};
    tbl[9] = '{8'h77, 3'b111, 24'h0,      32'h0,        32'h0,        6'd0,  -1, 32'h0,        24'h000001, 32'h12345678, 1'b0};

    bus.sclk = 1'b0; bus.ss = 1'b1; bus.mosi = 1'b0;
    bus.cmd_type = 3'b000; bus.tx_data = '0; bus.tx_nbits = '0;
    clks(4);
    check("rst_miso", {31'd0, bus.miso}, {31'd0, MISO_RST});
    check("rst_cmd", 32'(bus.cmd), 32'd0);
    check("rst_flags", 32'({bus.cmd_valid, bus.rx_valid, bus.tx_done, bus.frame_err}), 32'd0);
    check("rst_addr", 32'(bus.rx_address), 32'd0);
    check("rst_data", bus.rx_data, 32'd0);
    rst = 1'b0;
    clks(10);

    for (int i = 0; i < 10; i++) begin
      tn   = norm(tbl[i].t);
      nans = ans_len(tn, tbl[i].nb);
      xfer(tbl[i].c, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].txd, tbl[i].nb, tbl[i].nclk, 1'b0, ans);
      check($sformatf("v%0d_cmd", i), 32'(bus.cmd), 32'(tbl[i].c));
      check($sformatf("v%0d_addr", i), 32'(bus.rx_address), 32'(tbl[i].e_a));
      check($sformatf("v%0d_data", i), bus.rx_data, tbl[i].e_d);
      check($sformatf("v%0d_cmd_valid", i), 32'(d_cv), 32'd1);
      check($sformatf("v%0d_rx_valid", i), 32'(d_rv), 32'(!tbl[i].e_err));
      check($sformatf("v%0d_frame_err", i), 32'(d_fe), 32'(tbl[i].e_err));
      check($sformatf("v%0d_tx_done", i), 32'(d_td), 32'(nans > 0 && !tbl[i].e_err));
      if (nans > 0) check($sformatf("v%0d_answer", i), ans, tbl[i].e_ans);
      else          check($sformatf("v%0d_miso_quiet", i), 32'(d_m1), 32'd0);
    end

    // reset in the middle of the answer phase, then a clean read-ID frame
    xfer(8'h9F, 3'b001, 24'h0, 32'h0, 32'hFFFFFFFF, 6'd32, 18, 1'b1, ans);
    check("rstmid_frame_err", 32'(d_fe), 32'd0);
    check("rstmid_rx_valid", 32'(d_rv), 32'd0);
    check("rstmid_tx_done", 32'(d_td), 32'd0);
    m_cmd = '0; m_addr = '0; m_data = '0;
    run_model(8'h9F, 3'b001, 24'h0, 32'h0, 32'hC2201600, 6'd24, -1);

    for (int i = 0; i < 20; i++) begin
      t    = 3'($urandom_range(0, 7));
      nclk = -1;
      if ($urandom_range(0, 3) == 0) nclk = $urandom_range(0, rx_len(norm(t)) - 1);
      run_model(8'($urandom), t, 24'($urandom), $urandom, $urandom,
                6'($urandom_range(0, 32)), nclk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
